hls_deadlock_monitor_param: RTL and testbench

Parametrised deadlock monitor for one HLS dataflow region of NUM_PROC processes. It flags a deadlock when at least one process is stalled on an AXI-Stream port and every process is stopped (idle, channel-blocked or AXIS-blocked). The condition must hold for CONFIRM_CYCLES consecutive cycles before it is reported. The block sits beside the dataflow top and feeds a sticky flag, an event counter and an optional first-deadlock snapshot to the debug/status register bank.

---
 rtl/hls_deadlock_mon_pkg.sv | 15 +
 rtl/hls_deadlock_confirm_filter.sv | 83 ++++++++
 rtl/hls_deadlock_monitor_param.sv | 93 +++++++++
 tb/tb_hls_deadlock_monitor_param.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_deadlock_mon_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock monitor.
package hls_deadlock_mon_pkg;

  typedef enum logic [1:0] {
    WATCH   = 2'd0,
    CONFIRM = 2'd1,
    BLOCKED = 2'd2
  } mon_state_t;

  // Counter must hold values up to CONFIRM_CYCLES without wrapping.
  function automatic int confirm_cnt_w(input int confirm_cycles);
    return $clog2(confirm_cycles + 1);
  endfunction

endpackage

// File: rtl/hls_deadlock_confirm_filter.sv
// Consecutive-cycle confirmation filter: a candidate must persist for
// CONFIRM_CYCLES cycles before the blocked level is raised.
//
// state   | meaning
// --------+---------------------------------------------------------
// WATCH   | no candidate seen, counter idle at 0
// CONFIRM | candidate seen for cnt consecutive cycles, not yet enough
// BLOCKED | candidate held long enough; blocked = 1 until it drops
module hls_deadlock_confirm_filter
  import hls_deadlock_mon_pkg::*;
#(
  parameter int CONFIRM_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic candidate,
  output logic blocked,
  output logic confirm
);

  localparam int CW = confirm_cnt_w(CONFIRM_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CONFIRM_CYCLES - 1);

  mon_state_t     state;
  logic [CW-1:0]  cnt;

  // Combinational so the top-level registers update on the same edge as blocked.
  always_comb begin
    confirm = 1'b0;
    if (candidate) begin
      if (state == WATCH && CONFIRM_CYCLES == 1)
        confirm = 1'b1;
      else if (state == CONFIRM && cnt == LAST)
        confirm = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= WATCH;
      cnt     <= '0;
      blocked <= 1'b0;
    end else begin
      case (state)
        WATCH: begin
          if (candidate) begin
            if (CONFIRM_CYCLES == 1) begin
              state   <= BLOCKED;
              blocked <= 1'b1;
            end else begin
              state <= CONFIRM;
              cnt   <= CW'(1);
            end
          end
        end
        CONFIRM: begin
          if (!candidate) begin
            state <= WATCH;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state   <= BLOCKED;
            cnt     <= '0;
            blocked <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BLOCKED: begin
          if (!candidate) begin
            state   <= WATCH;
            blocked <= 1'b0;
          end
        end
        default: begin
          state   <= WATCH;
          cnt     <= '0;
          blocked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hls_deadlock_monitor_param.sv
// Deadlock monitor for one HLS dataflow region: sticky flag, saturating event
// counter and, with HLS_DEADLOCK_MON_SNAPSHOT_EN defined, a first-deadlock snapshot.
module hls_deadlock_monitor_param
  import hls_deadlock_mon_pkg::*;
#(
  parameter int NUM_PROC       = 5,
  parameter int CONFIRM_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic [NUM_PROC-1:0] inst_idle_sigs,
  input  logic [NUM_PROC-1:0] inst_block_sigs,
  input  logic [NUM_PROC-1:0] axis_block_sigs,
  output logic                block,
  output logic                block_sticky,
  output logic [CNT_W-1:0]    block_count,
  output logic [NUM_PROC-1:0] snap_chan_block,
  output logic [NUM_PROC-1:0] snap_axis_block
);

  if (NUM_PROC < 1) begin : g_bad_num_proc
    $error("hls_deadlock_monitor_param: NUM_PROC must be >= 1");
  end
  if (CONFIRM_CYCLES < 1) begin : g_bad_confirm
    $error("hls_deadlock_monitor_param: CONFIRM_CYCLES must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hls_deadlock_monitor_param: CNT_W must be >= 1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_PROC-1:0] stop;
  logic                candidate;
  logic                confirm;

  // A region is only reported when an AXIS stall is involved and nobody can progress.
  assign stop      = inst_idle_sigs | inst_block_sigs | axis_block_sigs;
  assign candidate = (|axis_block_sigs) & (&stop);

  hls_deadlock_confirm_filter #(
    .CONFIRM_CYCLES (CONFIRM_CYCLES)
  ) u_filter (
    .clock     (clock),
    .reset     (reset),
    .candidate (candidate),
    .blocked   (block),
    .confirm   (confirm)
  );

  // A confirmation coinciding with clear counts as the first event after clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      block_sticky <= 1'b0;
      block_count  <= '0;
    end else if (confirm) begin
      block_sticky <= 1'b1;
      if (clear)
        block_count <= CNT_W'(1);
      else if (block_count != CNT_MAX)
        block_count <= block_count + CNT_W'(1);
    end else if (clear) begin
      block_sticky <= 1'b0;
      block_count  <= '0;
    end
  end

`ifdef HLS_DEADLOCK_MON_SNAPSHOT_EN
  logic snap_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      snap_valid      <= 1'b0;
      snap_chan_block <= '0;
      snap_axis_block <= '0;
    end else if (confirm) begin
      if (!snap_valid || clear) begin
        snap_valid      <= 1'b1;
        snap_chan_block <= inst_block_sigs;
        snap_axis_block <= axis_block_sigs;
      end
    end else if (clear) begin
      snap_valid <= 1'b0;
    end
  end
`else
  assign snap_chan_block = '0;
  assign snap_axis_block = '0;
`endif

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Bench for hls_deadlock_monitor_param: two instances (CONFIRM_CYCLES 1 and 16)
// checked every cycle against a run-length model plus directed literal checks.
module tb_hls_deadlock_monitor_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [4:0] idle  = '0;
  logic [4:0] chan  = '0;
  logic [4:0] axis  = '0;

  logic       a_block, a_sticky, b_block, b_sticky;
  logic [1:0] a_count;
  logic [7:0] b_count;
  logic [4:0] a_snap_c, a_snap_a, b_snap_c, b_snap_a;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  hls_deadlock_monitor_param #(.NUM_PROC(5), .CONFIRM_CYCLES(1), .CNT_W(2)) dut_a (
    .clock(clock), .reset(reset), .clear(clear),
    .inst_idle_sigs(idle), .inst_block_sigs(chan), .axis_block_sigs(axis),
    .block(a_block), .block_sticky(a_sticky), .block_count(a_count),
    .snap_chan_block(a_snap_c), .snap_axis_block(a_snap_a));

  hls_deadlock_monitor_param #(.NUM_PROC(5), .CONFIRM_CYCLES(16), .CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .clear(clear),
    .inst_idle_sigs(idle), .inst_block_sigs(chan), .axis_block_sigs(axis),
    .block(b_block), .block_sticky(b_sticky), .block_count(b_count),
    .snap_chan_block(b_snap_c), .snap_axis_block(b_snap_a));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: block follows the length of the current unbroken candidate run;
  // a confirmation is the cycle the run reaches exactly CONFIRM_CYCLES.
  int         cc[2]   = '{1, 16};
  int         cmax[2] = '{3, 255};
  int         run[2]  = '{0, 0};
  bit         m_block[2]  = '{0, 0};
  bit         m_sticky[2] = '{0, 0};
  int         m_count[2]  = '{0, 0};
  bit         m_valid[2]  = '{0, 0};
  logic [4:0] m_snap_c[2] = '{5'd0, 5'd0};
  logic [4:0] m_snap_a[2] = '{5'd0, 5'd0};

  always @(posedge clock) begin
    automatic bit cand = (|axis) && (&(idle | chan | axis));
    for (int k = 0; k < 2; k++) begin
      automatic int r;
      automatic bit conf;
      if (reset) begin
        run[k]      <= 0;
        m_block[k]  <= 1'b0;
        m_sticky[k] <= 1'b0;
        m_count[k]  <= 0;
        m_valid[k]  <= 1'b0;
        m_snap_c[k] <= '0;
        m_snap_a[k] <= '0;
      end else begin
        r = cand ? run[k] + 1 : 0;
        if (r > 1000) r = 1000;
        conf = (r == cc[k]);
        run[k]     <= r;
        m_block[k] <= (r >= cc[k]);
        if (conf) begin
          m_sticky[k] <= 1'b1;
          if (clear) m_count[k] <= 1;
          else m_count[k] <= (m_count[k] < cmax[k]) ? m_count[k] + 1 : cmax[k];
          if (!m_valid[k] || clear) begin
            m_valid[k] <= 1'b1;
`ifdef HLS_DEADLOCK_MON_SNAPSHOT_EN
            m_snap_c[k] <= chan;
            m_snap_a[k] <= axis;
`endif
          end
        end else if (clear) begin
          m_sticky[k] <= 1'b0;
          m_count[k]  <= 0;
          m_valid[k]  <= 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("a_block",  a_block,  m_block[0]);
      check("a_sticky", a_sticky, m_sticky[0]);
      check("a_count",  a_count,  m_count[0]);
      check("a_snap_c", a_snap_c, m_snap_c[0]);
      check("a_snap_a", a_snap_a, m_snap_a[0]);
      check("b_block",  b_block,  m_block[1]);
      check("b_sticky", b_sticky, m_sticky[1]);
      check("b_count",  b_count,  m_count[1]);
      check("b_snap_c", b_snap_c, m_snap_c[1]);
      check("b_snap_a", b_snap_a, m_snap_a[1]);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_c, exp_a;

    tick(2);
    chk_en = 1'b1;
    check("rst_a_block", a_block, 0);
    check("rst_a_count", a_count, 0);
    check("rst_b_count", b_count, 0);
    check("rst_b_snap_a", b_snap_a, 0);

    // C=1: proc1 axis-blocked, others idle from cycle 0.
    reset = 1'b0;
    idle = 5'b11101; axis = 5'b00010;
    tick();
    check("c1_block_rise", a_block, 1);
    check("c1_count", a_count, 1);
    check("c1_b_block", b_block, 0);
    tick(4);
    axis = 5'b00000;
    tick();
    check("c1_block_fall", a_block, 0);

    // Saturating 2-bit counter: 1,2,3,3,3 then clear with a sixth confirmation.
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      axis = 5'b00010;
      tick();
      check("sat_count", a_count, (i < 2) ? i + 1 : 3);
      axis = 5'b00000;
      tick();
    end
    axis = 5'b00010; clear = 1'b1;
    tick();
    check("clr_conf_count", a_count, 1);
    check("clr_conf_sticky", a_sticky, 1);
    clear = 1'b0; axis = 5'b00000;
    tick();

    // Snapshot keeps the first deadlock until cleared.
    pulse_clear();
    idle = 5'b10001; chan = 5'b01100; axis = 5'b00010;
    tick();
    idle = 5'b00000; chan = 5'b00000; axis = 5'b00000;
    tick();
    idle = 5'b01111; axis = 5'b10000;
    tick();
    idle = 5'b00000; axis = 5'b00000;
    tick();
`ifdef HLS_DEADLOCK_MON_SNAPSHOT_EN
    exp_c = 5'b01100; exp_a = 5'b00010;
`else
    exp_c = 5'b00000; exp_a = 5'b00000;
`endif
    check("snap1_chan", a_snap_c, exp_c);
    check("snap1_axis", a_snap_a, exp_a);
    check("snap_count", a_count, 2);
    pulse_clear();
    idle = 5'b11000; chan = 5'b00110; axis = 5'b00001;
    tick();
    idle = 5'b00000; chan = 5'b00000; axis = 5'b00000;
    tick();
`ifdef HLS_DEADLOCK_MON_SNAPSHOT_EN
    exp_c = 5'b00110; exp_a = 5'b00001;
`else
    exp_c = 5'b00000; exp_a = 5'b00000;
`endif
    check("snap3_chan", a_snap_c, exp_c);
    check("snap3_axis", a_snap_a, exp_a);

    // C=16: 15 high, 1 low, then 16 high.
    pulse_clear();
    idle = 5'b11101; axis = 5'b00010;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("c16_win1_block", b_block, 0);
    end
    axis = 5'b00000;
    tick();
    check("c16_gap_block", b_block, 0);
    axis = 5'b00010;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("c16_win2_block", b_block, (i == 16) ? 1 : 0);
    end
    check("c16_count", b_count, 1);
    check("c16_sticky", b_sticky, 1);

    // Idle everywhere, no AXIS stall: never a deadlock.
    idle = 5'b11111; axis = 5'b00000; clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_a_block", a_block, 0);
      check("idle_b_block", b_block, 0);
    end
    check("idle_a_count", a_count, 0);
    check("idle_b_count", b_count, 0);

    // Reset in the 10th CONFIRM cycle, candidate held throughout.
    idle = 5'b11101; axis = 5'b00010;
    tick(10);
    check("pre_rst_b_block", b_block, 0);
    reset = 1'b1;
    tick();
    check("in_rst_b_block", b_block, 0);
    check("in_rst_b_count", b_count, 0);
    check("in_rst_a_sticky", a_sticky, 0);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("post_rst_b_block", b_block, (i == 16) ? 1 : 0);
    end
    check("post_rst_b_count", b_count, 1);

    axis = 5'b00000; idle = 5'b00000;
    tick(2);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
